seq_alu_muldiv: RTL and testbench
=================================

// Module: seq_alu_muldiv
// PURPOSE
//  Multi-cycle signed ALU: add, sub, mul, div, mod on WIDTH-bit two's-complement operands, 2*WIDTH-bit result.
//  Replaces the combinational loop-based multiplier/divider with a shift-add multiplier and a restoring divider.
//  Each iteration processes one bit per clock, so timing is bounded and the block is synthesizable.
//  Sits between the operand/opcode source and the result register bank; uses a start/done handshake.
// PARAMETERS
//  WIDTH  16  operand width in bits (>=4); result width is 2*WIDTH; iteration counter is $clog2(WIDTH) bits
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        request; accepted on a rising edge when busy==0
//  op_code    in   4        0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-15 invalid
//  operand_a  in   WIDTH    signed operand A (dividend)
//  operand_b  in   WIDTH    signed operand B (divisor)
//  busy       out  1        1 while an accepted op is in CALC or FIX
//  done       out  1        one-cycle pulse; result/err_code are valid from this cycle onward
//  result     out  2*WIDTH  signed result; held until the next done
//  err_code   out  2        00 ok, 01 add/sub overflow, 10 divide by zero, 11 invalid opcode
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, err_code=00, counter=0.
//  Accept: on an edge with start=1 and state in {IDLE, DONE}, latch op_code, operand_a and operand_b.
//   start is ignored while busy=1.
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE -> CALC on accept; goes to FIX instead for op 3/4 with b==0, or for op 5-15.
//   CALC: counter loads 0 for add/sub and WIDTH-1 for mul/div/mod; decrements once per edge; -> FIX when counter==0.
//   FIX -> DONE: apply sign correction, register result and err_code.
//   DONE: done=1 for this cycle only. Next state is CALC/FIX if start=1 (back-to-back accept), else IDLE.
//  Latency, counted as edges from the accepting edge to the edge that raises done:
//   add/sub 3; mul/div/mod WIDTH+2; divide-by-zero and invalid opcode 2.
//  add/sub: full-precision signed sum/difference, sign-extended to 2*WIDTH.
//   err=01 if the true result lies outside [-2^(W-1), 2^(W-1)-1]; result still carries the exact value.
//  mul: operate on magnitudes, one shift-add step per CALC cycle. FIX negates if sign(a)^sign(b).
//   Result is exact in 2*WIDTH bits, including (-2^(W-1))*(-2^(W-1)). err=00.
//  div/mod: restoring division on magnitudes, one quotient bit per CALC cycle.
//   Quotient truncates toward zero. Remainder takes the sign of the dividend.
//   div returns the quotient, mod the remainder, both sign-extended to 2*WIDTH.
//   -2^(W-1) / -1 = +2^(W-1), representable in 2*WIDTH bits, so err=00.
//  Divide by zero (op 3/4, b==0): result=0, err=10. Invalid opcode: result=0, err=11.
//  busy=1 exactly in CALC and FIX. done and busy are never both 1.
//  Operand inputs may change after the accepting edge without affecting the in-flight op.
//  Reset mid-operation: the op is aborted, no done pulse, and all outputs return to reset values immediately.
//  result/err_code change only at the edge that enters DONE; otherwise they hold their last value.
// TESTING (WIDTH=16)
//  mul 11*15, start 1 cycle -> done 18 edges later, result=165, err=00; busy high for 17 cycles before done.
//  mul 32000*16000 -> result=512000000, err=00.
//   mul -32768*-32768 -> result=1073741824.
//  div -7/2 -> result=-3; mod -7/2 -> result=-1. div 7/-2 -> -3; mod 7/-2 -> 1; div -32768/-1 -> 32768.
//  add 32000+16000 -> result=48000, err=01. sub -32768-1 -> result=-32769, err=01. add 11+15 -> 26, err=00 at 3 edges.
//  div 11/0 -> result=0, err=10, done 2 edges after accept. op_code=4'b1001 -> result=0, err=11.
//  start held high through DONE: the second op is accepted in the DONE cycle and its done follows with no idle gap.
//   Pulse start while busy -> ignored, no extra done.
//  Assert rst_n=0 at CALC cycle 5 of a mul -> busy/done/result/err all 0 asynchronously; no done after release.

Source files
------------

// File: rtl/seq_alu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_muldiv_if
// Description : Request/response bundle between operand source and ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_muldiv_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [3:0]           op_code;
    logic [WIDTH-1:0]     operand_a;
    logic [WIDTH-1:0]     operand_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic [1:0]           err_code;

    modport master (
        output start, op_code, operand_a, operand_b,
        input  busy, done, result, err_code
    );

    modport slave (
        input  start, op_code, operand_a, operand_b,
        output busy, done, result, err_code
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_muldiv
// Description : Multi-cycle signed ALU: add/sub/shift-add mul/restoring div.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  wire              clk,
    input  wire              rst_n,
    seq_alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_MUL = 4'd2;
    localparam logic [3:0] c_OP_DIV = 4'd3;
    localparam logic [3:0] c_OP_MOD = 4'd4;
    localparam logic [1:0] c_ERR_OK   = 2'b00;
    localparam logic [1:0] c_ERR_OVF  = 2'b01;
    localparam logic [1:0] c_ERR_DIV0 = 2'b10;
    localparam logic [1:0] c_ERR_INV  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_op;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]    r_rem;
    logic [WIDTH-1:0]    r_quo;
    logic [2*WIDTH-1:0]  r_result;
    logic [1:0]          r_err;

    logic                w_accept;
    logic                w_skip_calc;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [2*WIDTH-1:0]  w_mul_next;
    logic [WIDTH:0]      w_rem_sh;
    logic [WIDTH-1:0]    w_rem_sub;
    logic                w_q_bit;
    logic [2*WIDTH-1:0]  w_quo_ext;
    logic [2*WIDTH-1:0]  w_rem_ext;

    assign w_accept    = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
    // Divide-by-zero and invalid opcodes go straight to FIX to report the error.
    assign w_skip_calc = (bus.op_code > c_OP_MOD) ||
                         (((bus.op_code == c_OP_DIV) || (bus.op_code == c_OP_MOD)) &&
                          (bus.operand_b == '0));

    // Magnitude of -2^(W-1) is 2^(W-1), which still fits as an unsigned W-bit value.
    assign w_a_mag = r_a[WIDTH-1] ? (~r_a + 1'b1) : r_a;
    assign w_b_mag = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;

    assign w_mul_next = {r_acc[2*WIDTH-2:0], 1'b0} +
                        (w_b_mag[r_cnt] ? {{WIDTH{1'b0}}, w_a_mag} : '0);

    // The partial remainder stays below |b| <= 2^(W-1), so W bits hold the difference.
    assign w_rem_sh  = {r_rem, w_a_mag[r_cnt]};
    assign w_q_bit   = (w_rem_sh >= {1'b0, w_b_mag});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - w_b_mag;

    assign w_quo_ext = {{WIDTH{1'b0}}, r_quo};
    assign w_rem_ext = {{WIDTH{1'b0}}, r_rem};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept)
                    w_state_next = w_skip_calc ? ST_FIX : ST_CALC;
                else
                    w_state_next = ST_IDLE;
            end
            ST_CALC: if (r_cnt == '0) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_err    <= c_ERR_OK;
        end else begin
            if (w_accept) begin
                r_op  <= bus.op_code;
                r_a   <= bus.operand_a;
                r_b   <= bus.operand_b;
                r_cnt <= (bus.op_code <= c_OP_SUB) ? '0 : c_CNT_LAST;
                r_acc <= '0;
                r_rem <= '0;
                r_quo <= '0;
            end else if (r_state == ST_CALC) begin
                if (r_cnt != '0)
                    r_cnt <= r_cnt - 1'b1;
                case (r_op)
                    c_OP_ADD: r_acc <= {{WIDTH{r_a[WIDTH-1]}}, r_a} + {{WIDTH{r_b[WIDTH-1]}}, r_b};
                    c_OP_SUB: r_acc <= {{WIDTH{r_a[WIDTH-1]}}, r_a} - {{WIDTH{r_b[WIDTH-1]}}, r_b};
                    c_OP_MUL: r_acc <= w_mul_next;
                    default: begin
                        r_rem <= w_q_bit ? w_rem_sub : w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
                    end
                endcase
            end else if (r_state == ST_FIX) begin
                case (r_op)
                    c_OP_ADD, c_OP_SUB: begin
                        r_result <= r_acc;
                        r_err    <= (r_acc[WIDTH] != r_acc[WIDTH-1]) ? c_ERR_OVF : c_ERR_OK;
                    end
                    c_OP_MUL: begin
                        r_result <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (~r_acc + 1'b1) : r_acc;
                        r_err    <= c_ERR_OK;
                    end
                    c_OP_DIV, c_OP_MOD: begin
                        if (r_b == '0) begin
                            r_result <= '0;
                            r_err    <= c_ERR_DIV0;
                        end else if (r_op == c_OP_DIV) begin
                            r_result <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (~w_quo_ext + 1'b1) : w_quo_ext;
                            r_err    <= c_ERR_OK;
                        end else begin
                            r_result <= r_a[WIDTH-1] ? (~w_rem_ext + 1'b1) : w_rem_ext;
                            r_err    <= c_ERR_OK;
                        end
                    end
                    default: begin
                        r_result <= '0;
                        r_err    <= c_ERR_INV;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.result   = r_result;
    assign bus.err_code = r_err;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu_muldiv
// Description : Directed self-checking bench for seq_alu_muldiv (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu_muldiv;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;

    seq_alu_muldiv_if #(.WIDTH(WIDTH)) bus ();

    seq_alu_muldiv #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency is counted including the accepting edge.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_res, input logic [1:0] exp_err,
                          input int exp_lat, input bit poke);
        int n;
        int busy_n;
        int both_n;
        int extra;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op_code   = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk);
        #1;
        n = 1;
        busy_n = 0;
        both_n = 0;
        bus.operand_a = 16'($urandom);
        bus.operand_b = 16'($urandom);
        bus.op_code   = 4'($urandom);
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_n++;
            bus.start = (poke && n == 5);
            if (poke && n == 5) bus.op_code = 4'd0;
            @(posedge clk);
            n++;
            #1;
        end
        bus.start = 1'b0;
        if (bus.busy && bus.done) both_n++;
        check({tag, "_lat"},    64'(n),        64'(exp_lat));
        check({tag, "_busy"},   64'(busy_n),   64'(exp_lat - 1));
        check({tag, "_res"},    64'(bus.result),   64'(exp_res));
        check({tag, "_err"},    64'(bus.err_code), 64'(exp_err));
        extra = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
            if (bus.busy && bus.done) both_n++;
        end
        check({tag, "_onepulse"}, 64'(extra), 64'd0);
        check({tag, "_hold"},     64'(bus.result), 64'(exp_res));
        check({tag, "_bothhi"},   64'(both_n), 64'd0);
    endtask

    initial begin
        int n;
        int extra;
        bus.start     = 1'b0;
        bus.op_code   = 4'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        #12;
        check("rst_busy",   64'(bus.busy),     64'd0);
        check("rst_done",   64'(bus.done),     64'd0);
        check("rst_result", 64'(bus.result),   64'd0);
        check("rst_err",    64'(bus.err_code), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op("mul_11x15",   4'd2, 16'd11,     16'd15,     32'd165,        2'b00, 18, 1'b0);
        run_op("mul_big",     4'd2, 16'd32000,  16'd16000,  32'd512000000,  2'b00, 18, 1'b0);
        run_op("mul_minmin",  4'd2, 16'sh8000,  16'sh8000,  32'd1073741824, 2'b00, 18, 1'b0);
        run_op("mul_neg",     4'd2, -16'sd3,    16'sd5,     -32'sd15,       2'b00, 18, 1'b0);
        run_op("div_m7_2",    4'd3, -16'sd7,    16'sd2,     -32'sd3,        2'b00, 18, 1'b0);
        run_op("mod_m7_2",    4'd4, -16'sd7,    16'sd2,     -32'sd1,        2'b00, 18, 1'b0);
        run_op("div_7_m2",    4'd3, 16'sd7,     -16'sd2,    -32'sd3,        2'b00, 18, 1'b0);
        run_op("mod_7_m2",    4'd4, 16'sd7,     -16'sd2,    32'sd1,         2'b00, 18, 1'b0);
        run_op("div_min_m1",  4'd3, 16'sh8000,  -16'sd1,    32'd32768,      2'b00, 18, 1'b0);
        run_op("div_1000_7",  4'd3, 16'sd1000,  16'sd7,     32'sd142,       2'b00, 18, 1'b0);
        run_op("mod_1000_7",  4'd4, 16'sd1000,  16'sd7,     32'sd6,         2'b00, 18, 1'b0);
        run_op("add_ovf",     4'd0, 16'sd32000, 16'sd16000, 32'sd48000,     2'b01, 3,  1'b0);
        run_op("sub_ovf",     4'd1, 16'sh8000,  16'sd1,     -32'sd32769,    2'b01, 3,  1'b0);
        run_op("add_11_15",   4'd0, 16'sd11,    16'sd15,    32'sd26,        2'b00, 3,  1'b0);
        run_op("sub_5_9",     4'd1, 16'sd5,     16'sd9,     -32'sd4,        2'b00, 3,  1'b0);
        run_op("div_by0",     4'd3, 16'sd11,    16'sd0,     32'd0,          2'b10, 2,  1'b0);
        run_op("mod_by0",     4'd4, 16'sd3,     16'sd0,     32'd0,          2'b10, 2,  1'b0);
        run_op("op_inv",      4'b1001, 16'sd4,  16'sd5,     32'd0,          2'b11, 2,  1'b0);
        run_op("mul_poke",    4'd2, -16'sd3,    16'sd7,     -32'sd21,       2'b00, 18, 1'b1);

        // Back-to-back: start held through DONE accepts the next op with no idle gap.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op_code   = 4'd0;
        bus.operand_a = 16'sd11;
        bus.operand_b = 16'sd15;
        @(posedge clk);
        #1;
        bus.op_code   = 4'd1;
        bus.operand_a = 16'sd5;
        bus.operand_b = 16'sd9;
        n = 1;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("b2b_first_lat", 64'(n), 64'd3);
        check("b2b_first_res", 64'(bus.result), 64'd26);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_nogap", 64'(bus.busy), 64'd1);
        n = 1;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("b2b_second_lat", 64'(n), 64'd3);
        check("b2b_second_res", 64'(bus.result), 64'hFFFF_FFFC);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op_code   = 4'd2;
        bus.operand_a = 16'sd100;
        bus.operand_b = 16'sd200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy",   64'(bus.busy),     64'd0);
        check("mrst_done",   64'(bus.done),     64'd0);
        check("mrst_result", 64'(bus.result),   64'd0);
        check("mrst_err",    64'(bus.err_code), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) extra++;
        end
        check("mrst_no_done", 64'(extra), 64'd0);
        run_op("post_rst_add", 4'd0, 16'sd11, 16'sd15, 32'sd26, 2'b00, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
